// File: rtl/digital_clock_alarm.sv
// Digital clock with alarm: 1 Hz timekeeping, debounced-edge button edits, 12/24h BCD display.
// Display is combinational from registers; button edits land 3 clk after first sample; no backpressure.
module digital_clock_alarm #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int ALARM_SECS    = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       mode12,
   input  logic       alarm_set,
   input  logic       alarm_en,
   input  logic       alarm_ack,
   input  logic       hrup,
   input  logic       minup,
   output logic [3:0] s1,
   output logic [3:0] s2,
   output logic [3:0] m1,
   output logic [3:0] m2,
   output logic [3:0] h1,
   output logic [3:0] h2,
   output logic       pm,
   output logic       alarm,
   output logic       tick
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW = $clog2(ALARM_SECS + 1);
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [AW-1:0] ACNT = AW'(ALARM_SECS);

   logic [PW-1:0] presc;
   logic [5:0]    sec, min, al_min;
   logic [4:0]    hour, al_hour;
   logic [1:0]    hr_sync, min_sync;
   logic          hr_prev, min_prev, hr_edge, min_edge;
   logic [AW-1:0] acnt;
   logic          alarm_q;

   logic          tick_raw, time_edit, tick_adv, alarm_hit;
   logic [5:0]    nsec, nmin;
   logic [4:0]    nhour;

   // Buttons are asynchronous: two-flop sync, then a registered rising-edge pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hr_sync  <= '0;
         min_sync <= '0;
         hr_prev  <= 1'b0;
         min_prev <= 1'b0;
         hr_edge  <= 1'b0;
         min_edge <= 1'b0;
      end else begin
         hr_sync  <= {hr_sync[0], hrup};
         min_sync <= {min_sync[0], minup};
         hr_prev  <= hr_sync[1];
         min_prev <= min_sync[1];
         hr_edge  <= hr_sync[1] & ~hr_prev;
         min_edge <= min_sync[1] & ~min_prev;
      end
   end

   always_comb begin
      tick_raw  = enable && (presc == PMAX);
      time_edit = !alarm_set && (min_edge || hr_edge);
      tick_adv  = tick_raw && !time_edit;
      nsec      = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
      nmin      = min;
      nhour     = hour;
      if (sec == 6'd59) begin
         nmin = (min == 6'd59) ? 6'd0 : min + 6'd1;
         if (min == 6'd59)
            nhour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end
      alarm_hit = tick_adv && alarm_en && (nsec == 6'd0) &&
                  (nmin == al_min) && (nhour == al_hour);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         presc <= '0;
      else if (!alarm_set && min_edge)
         presc <= '0;
      else if (enable)
         presc <= (presc == PMAX) ? '0 : presc + PW'(1);
   end

   // A time edit always wins over a coincident tick; minute edits restart the second.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec  <= '0;
         min  <= '0;
         hour <= '0;
      end else if (!alarm_set && min_edge) begin
         min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
         sec <= '0;
      end else if (!alarm_set && hr_edge) begin
         hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else if (tick_adv) begin
         sec  <= nsec;
         min  <= nmin;
         hour <= nhour;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         al_min  <= '0;
         al_hour <= '0;
      end else if (alarm_set && min_edge) begin
         al_min <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
      end else if (alarm_set && hr_edge) begin
         al_hour <= (al_hour == 5'd23) ? 5'd0 : al_hour + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alarm_q <= 1'b0;
         acnt    <= '0;
      end else if (alarm_hit) begin
         alarm_q <= 1'b1;
         acnt    <= ACNT;
      end else if (alarm_q) begin
         if (alarm_ack || !alarm_en) begin
            alarm_q <= 1'b0;
         end else if (tick_raw) begin
            if (acnt == AW'(1))
               alarm_q <= 1'b0;
            acnt <= acnt - AW'(1);
         end
      end
   end

   assign alarm = alarm_q;
   assign tick  = tick_raw;

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   logic [4:0] disp_hour, hr_shown;
   logic [5:0] disp_min, disp_sec;
   logic [7:0] sec_bcd, min_bcd, hr_bcd;

   always_comb begin
      disp_hour = alarm_set ? al_hour : hour;
      disp_min  = alarm_set ? al_min : min;
      disp_sec  = alarm_set ? 6'd0 : sec;
      hr_shown  = disp_hour;
      if (mode12) begin
         if (disp_hour == 5'd0)
            hr_shown = 5'd12;
         else if (disp_hour > 5'd12)
            hr_shown = disp_hour - 5'd12;
      end
      pm      = mode12 && (disp_hour >= 5'd12);
      sec_bcd = to_bcd(disp_sec);
      min_bcd = to_bcd(disp_min);
      hr_bcd  = to_bcd({1'b0, hr_shown});
   end

   assign s2 = sec_bcd[7:4];
   assign s1 = sec_bcd[3:0];
   assign m2 = min_bcd[7:4];
   assign m1 = min_bcd[3:0];
   assign h2 = hr_bcd[7:4];
   assign h1 = hr_bcd[3:0];

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed bench for digital_clock_alarm with TICKS_PER_SEC=4, ALARM_SECS=3.
module tb_digital_clock_alarm;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable, mode12, alarm_set, alarm_en, alarm_ack, hrup, minup;
   logic [3:0] s1, s2, m1, m2, h1, h2;
   logic       pm, alarm, tick;
   logic [23:0] disp;

   int checks = 0;
   int errors = 0;

   digital_clock_alarm #(.TICKS_PER_SEC(4), .ALARM_SECS(3)) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode12(mode12),
      .alarm_set(alarm_set), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
      .hrup(hrup), .minup(minup),
      .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
      .pm(pm), .alarm(alarm), .tick(tick)
   );

   always #5 clk = ~clk;

   assign disp = {h2, h1, m2, m1, s2, s1};

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_hr(input int n);
      for (int i = 0; i < n; i++) begin
         hrup = 1'b1; step(3);
         hrup = 1'b0; step(3);
      end
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) begin
         minup = 1'b1; step(3);
         minup = 1'b0; step(3);
      end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; mode12 = 1'b1; alarm_set = 1'b0;
      alarm_en = 1'b0; alarm_ack = 1'b0; hrup = 1'b0; minup = 1'b0;

      // reset state, before any clock edge
      #2;
      chk("rst_12h_disp", disp, 24'h120000);
      chk("rst_12h_pm", 24'(pm), 24'h0);
      mode12 = 1'b0;
      #1;
      chk("rst_24h_disp", disp, 24'h000000);
      chk("rst_alarm", 24'(alarm), 24'h0);
      chk("rst_tick", 24'(tick), 24'h0);
      step(2);
      rst = 1'b1;

      // hour edits with enable=0, button latency and long hold
      press_hr(5);
      chk("hr_to_05", disp, 24'h050000);
      hrup = 1'b1;
      step(3);
      chk("hr_latency_not_yet", disp, 24'h050000);
      step(1);
      chk("hr_latency_3rd_edge", disp, 24'h060000);
      step(96);
      hrup = 1'b0;
      step(3);
      chk("hr_hold_single", disp, 24'h060000);

      // 12-hour display mapping
      press_hr(6);
      mode12 = 1'b1; #1;
      chk("h12_noon", {16'h0, h2, h1}, 24'h12);
      chk("h12_noon_pm", 24'(pm), 24'h1);
      press_hr(1);
      chk("h12_13", {16'h0, h2, h1}, 24'h01);
      chk("h12_13_pm", 24'(pm), 24'h1);
      mode12 = 1'b0; #1;
      chk("h24_13", {16'h0, h2, h1}, 24'h13);
      chk("h24_13_pm", 24'(pm), 24'h0);
      press_hr(11);
      chk("hr_wrap_23_0", disp, 24'h000000);
      mode12 = 1'b1; #1;
      chk("h12_midnight", {16'h0, h2, h1}, 24'h12);
      chk("h12_midnight_pm", 24'(pm), 24'h0);
      mode12 = 1'b0;

      // alarm at 07:30, expiry after 3 ticks
      alarm_set = 1'b1;
      press_hr(7);
      press_min(30);
      chk("alarm_edit_disp", disp, 24'h073000);
      alarm_set = 1'b0; #1;
      chk("time_untouched", disp, 24'h000000);
      press_hr(7);
      press_min(29);
      chk("time_0729", disp, 24'h072900);
      alarm_en = 1'b1;
      enable = 1'b1;
      step(236);
      chk("time_072959", disp, 24'h072959);
      step(3);
      chk("tick_pulse", 24'(tick), 24'h1);
      chk("alarm_before", 24'(alarm), 24'h0);
      step(1);
      chk("time_073000", disp, 24'h073000);
      chk("alarm_rise", 24'(alarm), 24'h1);
      chk("tick_one_cycle", 24'(tick), 24'h0);
      step(8);
      chk("alarm_hold_2ticks", 24'(alarm), 24'h1);
      step(4);
      chk("alarm_expire", 24'(alarm), 24'h0);
      chk("time_073003", disp, 24'h073003);

      // alarm to 07:31, then acknowledge
      enable = 1'b0;
      alarm_set = 1'b1;
      press_min(1);
      chk("alset_disp_sec0", disp, 24'h073100);
      alarm_set = 1'b0; #1;
      chk("time_frozen", disp, 24'h073003);
      enable = 1'b1;
      step(224);
      chk("time_073059", disp, 24'h073059);
      step(4);
      chk("alarm2_rise", 24'(alarm), 24'h1);
      alarm_ack = 1'b1;
      step(1);
      chk("ack_clear", 24'(alarm), 24'h0);
      alarm_ack = 1'b0;
      enable = 1'b0;

      // minup edge coincident with tick at 10:10:59, alarm at 10:11
      alarm_set = 1'b1;
      press_hr(3);
      press_min(40);
      chk("alarm_1011", disp, 24'h101100);
      alarm_set = 1'b0;
      press_hr(3);
      press_min(39);
      chk("min_wrap_nocarry", disp, 24'h101000);
      enable = 1'b1;
      step(236);
      chk("time_101059", disp, 24'h101059);
      minup = 1'b1;
      step(3);
      chk("tick_at_edit", 24'(tick), 24'h1);
      step(1);
      chk("edit_beats_tick", disp, 24'h101100);
      chk("edit_no_alarm", 24'(alarm), 24'h0);
      step(2);
      chk("presc_restart_lo", 24'(tick), 24'h0);
      step(1);
      chk("presc_restart_hi", 24'(tick), 24'h1);
      step(1);
      chk("time_101101", disp, 24'h101101);
      chk("still_no_alarm", 24'(alarm), 24'h0);
      minup = 1'b0;
      enable = 1'b0;

      // day wrap with alarm at 00:00
      alarm_set = 1'b1;
      press_hr(14);
      press_min(49);
      chk("alarm_0000", disp, 24'h000000);
      alarm_set = 1'b0;
      press_hr(13);
      press_min(48);
      chk("time_2359", disp, 24'h235900);
      enable = 1'b1;
      step(236);
      chk("time_235959", disp, 24'h235959);
      step(4);
      chk("day_wrap", disp, 24'h000000);
      chk("alarm_midnight", 24'(alarm), 24'h1);
      step(5);
      chk("time_000001", disp, 24'h000001);

      // asynchronous reset mid-cycle, then first tick timing
      #3;
      rst = 1'b0;
      #1;
      chk("async_rst_disp", disp, 24'h000000);
      chk("async_rst_alarm", 24'(alarm), 24'h0);
      chk("async_rst_tick", 24'(tick), 24'h0);
      #2;
      rst = 1'b1;
      step(2);
      chk("post_rst_no_tick", 24'(tick), 24'h0);
      step(1);
      chk("post_rst_tick4", 24'(tick), 24'h1);
      step(1);
      chk("post_rst_sec1", disp, 24'h000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digital_clock_alarm.md
DIGITAL_CLOCK_ALARM -- requirements
Module: digital_clock_alarm

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, number of clk cycles per one-second tick (legal range >= 2).
REQ-002 Parameter ALARM_SECS, default 60, number of one-second ticks the alarm stays asserted (legal range >= 1).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-005 enable  in  1  1 = timekeeping runs; 0 = prescaler and time frozen.
REQ-006 mode12  in  1  display format: 0 = 24-hour, 1 = 12-hour.
REQ-007 alarm_set  in  1  1 = buttons edit the alarm time and the display shows the alarm time.
REQ-008 alarm_en  in  1  1 = alarm armed.
REQ-009 alarm_ack  in  1  1 = silence an active alarm.
REQ-010 hrup  in  1  asynchronous pushbutton; increments hour.
REQ-011 minup  in  1  asynchronous pushbutton; increments minute.
REQ-012 s1, s2, m1, m2, h1, h2  out  4 each  BCD ones/tens of seconds, minutes and hours.
REQ-013 pm  out  1  PM indicator in 12-hour mode.
REQ-014 alarm  out  1  alarm active.
REQ-015 tick  out  1  one-cycle pulse per one-second tick.

Function
REQ-016 Prescaler SHALL count 0..TICKS_PER_SEC-1 while enable=1, hold while enable=0, and wrap to 0.
REQ-017 tick SHALL pulse on the cycle where the prescaler equals TICKS_PER_SEC-1 and enable=1.
REQ-018 Each tick SHALL advance seconds; 59->0 carries to minutes; minutes 59->0 carries to hours; hours 23->0.
REQ-019 hrup and minup SHALL each pass through a 2-flop synchronizer and a rising-edge detector, giving exactly one increment per low-to-high press regardless of hold time.
REQ-020 A register update from a button SHALL be visible on the outputs at the 3rd rising clk edge after the first edge that samples the button high.
REQ-021 With alarm_set=0: a minup edge SHALL increment minutes (59->0, no hour carry), clear seconds and clear the prescaler; an hrup edge SHALL increment hours (23->0) and leave minutes and seconds unchanged.
REQ-022 With alarm_set=1: button edges SHALL modify alarm_hour/alarm_min with the same wrap rules; time and prescaler SHALL continue unaffected.
REQ-023 Priority in a single cycle SHALL be minup edge > hrup edge > tick; a time-edit edge drops any coincident tick.
REQ-024 Button edits SHALL work whether enable is 0 or 1.
REQ-025 Display, alarm_set=0: time registers; alarm_set=1: alarm_hour/alarm_min, with s1=s2=0.
REQ-026 Display, mode12=0: hours 00-23, pm=0; mode12=1: hour 0->12, 1-12 unchanged, 13-23->hour-12, pm=1 when hour>=12.
REQ-027 Binary-to-BCD conversion SHALL be combinational from the registers; no added latency.
REQ-028 Alarm SHALL trigger when a tick moves time to sec=0 with hour=alarm_hour, min=alarm_min and alarm_en=1; alarm rises one cycle after that tick.
REQ-029 Button edits SHALL never trigger the alarm.
REQ-030 alarm SHALL clear after ALARM_SECS further ticks, or on the cycle after alarm_ack=1, or on the cycle after alarm_en=0, whichever occurs first.
REQ-031 While alarm=1 the tick countdown SHALL run only when enable=1.

Reset
REQ-032 rst=0 SHALL immediately, without a clock edge, clear time, alarm time, prescaler, synchronizer and edge flops, the alarm countdown, alarm and tick.
REQ-033 In reset, all BCD outputs SHALL be 0 and pm=0 with mode12=0; with mode12=1, h2=1, h1=2 and pm=0.
REQ-034 After rst returns to 1, the first tick SHALL occur TICKS_PER_SEC enabled cycles later.

Verification (TICKS_PER_SEC=4, ALARM_SECS=3)
REQ-035 Time 23:59:59, enable=1 -> after the next tick, all six BCD outputs are 0.
REQ-036 hrup held high for 100 cycles from 05:00:00 -> hour=06 exactly, minutes and seconds unchanged by the press.
REQ-037 mode12=1: hour 0 -> h2=1, h1=2, pm=0; hour 13 -> h2=0, h1=1, pm=1; hour 12 -> 12, pm=1.
REQ-038 Alarm 07:30, alarm_en=1, time 07:29:59 -> alarm=1 one cycle after the tick, then 0 after 3 ticks; repeat with alarm_ack pulsed -> alarm=0 next cycle.
REQ-039 minup edge coincident with the tick at 10:10:59 -> 10:11:00, prescaler 0, alarm not triggered.
REQ-040 rst driven to 0 mid-count between clk edges -> outputs 0 and alarm=0 asynchronously; released -> first tick 4 cycles later.
